fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised N-wide fetch stage with a decoupling instruction queue, the next generation of the fixed 3-wide fetch stage. Each cycle it fetches up to WIDTH sequential instructions from instruction memory into a DEPTH-entry circular queue. It presents up to WIDTH oldest entries to dispatch, which consumes a variable number per cycle. Branch flush empties the queue and redirects the PC.

## Interface
- WIDTH, 3: instructions fetched and presented per cycle (1..4).
- DEPTH, 8: queue entries; power of 2, DEPTH >= WIDTH.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- branch_flush_en  in  1  flush queue and redirect fetch PC.
- target_pc  in  32  redirect PC when branch_flush_en=1; word aligned.
- Imem2proc_data  in  [WIDTH][64]  memory block for slot i. Combinational response to proc2Imem_addr[i].
- Imem2proc_valid  in  [WIDTH]  slot i data valid this cycle.
- dispatch_accept  in  $clog2(WIDTH+1)  number of presented entries dispatch takes this cycle.
- proc2Imem_addr  out  [WIDTH][32]  {pc_i[31:3],3'b000}, where pc_i = fetch_pc + 4*i.
- out_inst  out  [WIDTH][32]  instruction of queue entry head+i.
- out_pc  out  [WIDTH][32]  PC of entry head+i.
- out_npc  out  [WIDTH][32]  out_pc+4.
- out_valid  out  [WIDTH]  1 iff i < count.
- free_slots  out  $clog2(DEPTH+1)  DEPTH - count (registered count).

## Operation
- State:
  - fetch_pc, 32 bits.
  - head and tail, $clog2(DEPTH) bits each; wrap modulo DEPTH.
  - count, $clog2(DEPTH+1) bits.
  - Entry array of {inst, pc}.
- Slot instruction select: inst_i = pc_i[2] ? Imem2proc_data[i][63:32] : Imem2proc_data[i][31:0].
- Fetch prefix p: the number of leading slots with Imem2proc_valid set (contiguous from slot 0). A hole stops the prefix.
- Enqueue count k = min(p, WIDTH, DEPTH - count). Uses the registered count; slots freed by dequeue in the same cycle are not reused.
  - Slots 0..k-1 are written at tail..tail+k-1.
  - tail += k; fetch_pc += 4*k.
- Dequeue count d = min(dispatch_accept, count). dispatch_accept above count is clamped and is not an error.
  - head += d.
- count_next = count + k - d.
- Outputs are combinational from the queue head. Slots with out_valid=0 drive inst/pc/npc = 0.
- Flush (branch_flush_en=1) overrides both enqueue and dequeue:
  - head = tail = count = 0.
  - fetch_pc = target_pc.
  - Memory data in the flush cycle is discarded.
- Reset overrides flush:
  - fetch_pc = 0; head = tail = count = 0.
  - Entry contents are don't-care.
- proc2Imem_addr is always driven from fetch_pc, including while the queue is full or during flush.

## Timing
- Fetch-to-present latency is 1 cycle. An instruction enqueued at edge t is visible on out_* after edge t; there is no empty-queue bypass.
- Reset values:
  - out_valid = 0; out_inst, out_pc and out_npc = 0.
  - free_slots = DEPTH.
  - proc2Imem_addr[i] = {(4*i)[31:3],3'b0}. For WIDTH=3 this is {0,0,8}.
- Flush at edge t: after edge t, out_valid = 0 and proc2Imem_addr reflects target_pc. Target instructions become visible after edge t+1.
- Full queue: k = 0 and fetch_pc holds. If dispatch dequeues that cycle, fetch resumes on the next cycle.
- Empty queue with dispatch_accept > 0: d = 0 and no state change from dequeue.
- Reset asserted mid-stream: all state clears at that edge regardless of other inputs.

## Test plan
- Reset (WIDTH=3, DEPTH=8) -> out_valid=000, proc2Imem_addr={0,0,8}, free_slots=8.
- Fill, all Imem valid, dispatch_accept=0:
  - Edge 1 queues PCs 0,4,8; fetch_pc=12 and proc2Imem_addr={8,16,16}.
  - Edge 2: count=6, fetch_pc=24.
  - Edge 3 enqueues only 24,28: count=8, fetch_pc=32.
  - Edge 4: no change. out_pc={0,4,8} throughout.
- Partial dispatch from full: dispatch_accept=2 -> out_pc={8,12,16}, out_npc={12,16,20}, count=6, fetch_pc still 32. Next edge enqueues 2 (32,36).
- Valid hole: Imem2proc_valid=3'b101 at fetch_pc=0, with Imem data[0]={32'hc,32'h1} -> exactly 1 entry enqueued (inst 32'h1, pc 0); fetch_pc=4.
- Flush with dispatch_accept=3, target_pc=20:
  - Next cycle: out_valid=000, proc2Imem_addr={16,24,24}, count=0.
  - Following cycle: out_pc={20,24,28}, out_npc={24,28,32}. Inst selected from high words for PCs 20 and 28 (pc[2]=1) and the low word for PC 24.
- Wrap-around streaming: dispatch_accept=3, all valid, 12 cycles -> out_pc increases by 12 each cycle with no gaps or duplicates across head/tail wrap. count stays at 3 after warm-up.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Purpose
//   N-wide sequential fetch stage feeding a DEPTH-entry circular instruction
//   queue. Each cycle up to WIDTH instructions from the leading contiguous run
//   of valid memory slots are enqueued, subject to free space. Dispatch may
//   take any number of presented entries each cycle. A branch flush empties
//   the queue and redirects fetch.
//
// Parameters
//   WIDTH  fetch / present width, 1..4
//   DEPTH  queue entries, power of two, DEPTH >= WIDTH and DEPTH >= 2
//
// Ports
//   clock            system clock, all state changes on the rising edge
//   reset            synchronous, active-high; takes priority over flush
//   branch_flush_en  empty the queue and load fetch_pc from target_pc
//   target_pc        redirect PC (word aligned)
//   Imem2proc_data   per-slot 64-bit memory block answering proc2Imem_addr
//   Imem2proc_valid  per-slot data valid
//   dispatch_accept  number of presented entries taken by dispatch
//   proc2Imem_addr   per-slot 8-byte aligned block address of fetch_pc + 4*i
//   out_inst/out_pc  instruction and PC of queue entry head+i
//   out_npc          out_pc + 4
//   out_valid        slot i holds a live entry (i < count)
//   free_slots       DEPTH - count
// ---------------------------------------------------------------------------
module fetch_queue #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             branch_flush_en,
   input  logic [31:0]                      target_pc,
   input  logic [WIDTH-1:0][63:0]           Imem2proc_data,
   input  logic [WIDTH-1:0]                 Imem2proc_valid,
   input  logic [$clog2(WIDTH+1)-1:0]       dispatch_accept,
   output logic [WIDTH-1:0][31:0]           proc2Imem_addr,
   output logic [WIDTH-1:0][31:0]           out_inst,
   output logic [WIDTH-1:0][31:0]           out_pc,
   output logic [WIDTH-1:0][31:0]           out_npc,
   output logic [WIDTH-1:0]                 out_valid,
   output logic [$clog2(DEPTH+1)-1:0]       free_slots
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Architectural state
   logic [31:0]   fetch_pc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   // Entry storage
   logic [31:0]   entry_inst [DEPTH];
   logic [31:0]   entry_pc   [DEPTH];

   // Per-cycle combinational values
   logic [WIDTH-1:0][31:0]   slot_pc;
   logic [WIDTH-1:0][31:0]   slot_inst;
   logic [WIDTH-1:0]         wr_en;
   logic [WIDTH-1:0][PW-1:0] wr_idx;
   logic [WIDTH-1:0][PW-1:0] rd_idx;
   logic [CW-1:0]            prefix;
   logic [CW-1:0]            room;
   logic [CW-1:0]            enq_cnt;
   logic [CW-1:0]            deq_cnt;
   logic [CW-1:0]            accept_ext;
   logic                     hole;

   // Fetch side: slot addresses, word select and the valid prefix length.
   // NOTE: combinational blocks use blocking '=' and assign every output a
   // default first, so 'hole'/'prefix' accumulate in loop order and no latch
   // can be inferred.
   always_comb begin
      hole   = 1'b0;
      prefix = '0;
      for (int i = 0; i < WIDTH; i++) begin
         slot_pc[i]        = fetch_pc + 32'(4 * i);
         proc2Imem_addr[i] = {slot_pc[i][31:3], 3'b000};
         slot_inst[i]      = slot_pc[i][2] ? Imem2proc_data[i][63:32]
                                           : Imem2proc_data[i][31:0];
         // A hole ends the prefix: later valid slots are not sequential.
         if (!Imem2proc_valid[i]) hole = 1'b1;
         if (!hole) prefix = prefix + CW'(1);
      end
   end

   // Enqueue/dequeue counts. Room is based on the registered count, so
   // entries freed by this cycle's dispatch are not reused until next cycle.
   always_comb begin
      room       = CW'(DEPTH) - count;
      enq_cnt    = (prefix < room) ? prefix : room;
      accept_ext = CW'(dispatch_accept);
      deq_cnt    = (accept_ext < count) ? accept_ext : count;
   end

   // Queue indexing; PW-bit sums wrap modulo DEPTH because DEPTH is 2^PW.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         wr_idx[i] = tail + PW'(i);
         rd_idx[i] = head + PW'(i);
         wr_en[i]  = !branch_flush_en && (CW'(i) < enq_cnt);
      end
   end

   // Queue control state.
   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (branch_flush_en) begin
         fetch_pc <= target_pc;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         fetch_pc <= fetch_pc + (32'(enq_cnt) << 2);
         head     <= head + PW'(deq_cnt);
         tail     <= tail + PW'(enq_cnt);
         count    <= count + enq_cnt - deq_cnt;
      end
   end

   // Entry storage.
   // NOTE: the entry array has no reset; only entries below count are ever
   // observed, so stale contents are harmless and this maps to plain RAM.
   always_ff @(posedge clock) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (wr_en[i]) begin
            entry_inst[wr_idx[i]] <= slot_inst[i];
            entry_pc[wr_idx[i]]   <= slot_pc[i];
         end
      end
   end

   // Presentation: combinational from head, dead slots forced to zero.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         out_valid[i] = CW'(i) < count;
         out_inst[i]  = out_valid[i] ? entry_inst[rd_idx[i]] : '0;
         out_pc[i]    = out_valid[i] ? entry_pc[rd_idx[i]]   : '0;
         out_npc[i]   = out_valid[i] ? entry_pc[rd_idx[i]] + 32'd4 : '0;
      end
   end

   assign free_slots = room;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue (WIDTH=3, DEPTH=8): a directed vector
// table, hand-written hole and wrap-streaming sequences, then randomized
// traffic compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int W = 3;
   localparam int D = 8;

   logic             clock;
   logic             reset;
   logic             branch_flush_en;
   logic [31:0]      target_pc;
   logic [W-1:0][63:0] Imem2proc_data;
   logic [W-1:0]     Imem2proc_valid;
   logic [1:0]       dispatch_accept;
   logic [W-1:0][31:0] proc2Imem_addr;
   logic [W-1:0][31:0] out_inst;
   logic [W-1:0][31:0] out_pc;
   logic [W-1:0][31:0] out_npc;
   logic [W-1:0]     out_valid;
   logic [3:0]       free_slots;

   int n_cmp = 0;
   int n_bad = 0;

   // Memory override for the hand-written hole test.
   logic             ovr = 1'b0;
   logic [W-1:0][63:0] ovr_data;

   fetch_queue #(.WIDTH(W), .DEPTH(D)) dut (
      .clock           (clock),
      .reset           (reset),
      .branch_flush_en (branch_flush_en),
      .target_pc       (target_pc),
      .Imem2proc_data  (Imem2proc_data),
      .Imem2proc_valid (Imem2proc_valid),
      .dispatch_accept (dispatch_accept),
      .proc2Imem_addr  (proc2Imem_addr),
      .out_inst        (out_inst),
      .out_pc          (out_pc),
      .out_npc         (out_npc),
      .out_valid       (out_valid),
      .free_slots      (free_slots)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction image: a bijective scramble so every PC has a distinct word.
   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [63:0] mem_block(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:3], 3'b000};
      return {inst_of(base + 32'd4), inst_of(base)};
   endfunction

   // Combinational memory answering the DUT's addresses.
   always_comb begin
      for (int i = 0; i < W; i++)
         Imem2proc_data[i] = ovr ? ovr_data[i] : mem_block(proc2Imem_addr[i]);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One cycle: inputs are already set, outputs sampled at the falling edge.
   task automatic apply(input logic r, input logic f, input logic [31:0] t,
                        input logic [2:0] v, input logic [1:0] a);
      reset           = r;
      branch_flush_en = f;
      target_pc       = t;
      Imem2proc_valid = v;
      dispatch_accept = a;
      @(posedge clock);
      @(negedge clock);
   endtask

   // -------------------------------------------------------------------------
   // Reference model: a plain queue of {pc, inst} and a fetch PC.
   // -------------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mfpc;

   task automatic model_step(input logic r, input logic f, input logic [31:0] t,
                             input logic [2:0] v, input logic [1:0] a);
      int          p, k, d, room;
      logic [31:0] pc;
      logic [63:0] blk;
      ent_t        e;
      if (r) begin
         mq.delete();
         mfpc = '0;
      end else if (f) begin
         mq.delete();
         mfpc = t;
      end else begin
         room = D - mq.size();
         p = 0;
         while (p < W && v[p]) p++;
         k = (p < room) ? p : room;
         d = (int'(a) < mq.size()) ? int'(a) : mq.size();
         for (int i = 0; i < d; i++) void'(mq.pop_front());
         for (int i = 0; i < k; i++) begin
            pc     = mfpc + 32'(4 * i);
            blk    = ovr ? ovr_data[i] : mem_block(pc);
            e.pc   = pc;
            e.inst = pc[2] ? blk[63:32] : blk[31:0];
            mq.push_back(e);
         end
         mfpc = mfpc + 32'(4 * k);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] epc, einst, enpc;
      logic        ev;
      for (int i = 0; i < W; i++) begin
         ev    = i < mq.size();
         epc   = ev ? mq[i].pc : '0;
         einst = ev ? mq[i].inst : '0;
         enpc  = ev ? mq[i].pc + 32'd4 : '0;
         check($sformatf("%s.valid%0d", tag, i), 32'(out_valid[i]), 32'(ev));
         check($sformatf("%s.pc%0d", tag, i), out_pc[i], epc);
         check($sformatf("%s.npc%0d", tag, i), out_npc[i], enpc);
         check($sformatf("%s.inst%0d", tag, i), out_inst[i], einst);
         check($sformatf("%s.addr%0d", tag, i), proc2Imem_addr[i],
               (mfpc + 32'(4 * i)) & ~32'd7);
      end
      check($sformatf("%s.free", tag), 32'(free_slots), 32'(D - mq.size()));
   endtask

   // -------------------------------------------------------------------------
   // Directed vector table
   // -------------------------------------------------------------------------
   typedef struct {
      logic               rst;
      logic               flush;
      logic [31:0]        target;
      logic [2:0]         valid;
      logic [1:0]         acc;
      logic [2:0]         e_valid;
      logic [W-1:0][31:0] e_pc;
      logic [3:0]         e_free;
      logic [W-1:0][31:0] e_addr;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic flush, input int target,
                               input logic [2:0] valid, input int acc,
                               input logic [2:0] ev, input int p0, input int p1,
                               input int p2, input int free, input int a0,
                               input int a1, input int a2);
      vec_t x;
      x.rst = rst; x.flush = flush; x.target = 32'(target);
      x.valid = valid; x.acc = 2'(acc); x.e_valid = ev;
      x.e_pc[0] = 32'(p0); x.e_pc[1] = 32'(p1); x.e_pc[2] = 32'(p2);
      x.e_free = 4'(free);
      x.e_addr[0] = 32'(a0); x.e_addr[1] = 32'(a1); x.e_addr[2] = 32'(a2);
      return x;
   endfunction

   vec_t vecs[14];

   initial begin
      logic [31:0] epc;
      logic        r, f;
      logic [31:0] t;
      logic [2:0]  v;
      logic [1:0]  a;

      vecs[0]  = mk(1, 0,   0, 3'b000, 0, 3'b000,  0,  0,  0, 8,  0,  0,  8);
      vecs[1]  = mk(0, 0,   0, 3'b111, 0, 3'b111,  0,  4,  8, 5,  8, 16, 16);
      vecs[2]  = mk(0, 0,   0, 3'b111, 0, 3'b111,  0,  4,  8, 2, 24, 24, 32);
      vecs[3]  = mk(0, 0,   0, 3'b111, 0, 3'b111,  0,  4,  8, 0, 32, 32, 40);
      vecs[4]  = mk(0, 0,   0, 3'b111, 0, 3'b111,  0,  4,  8, 0, 32, 32, 40);
      vecs[5]  = mk(0, 0,   0, 3'b111, 2, 3'b111,  8, 12, 16, 2, 32, 32, 40);
      vecs[6]  = mk(0, 0,   0, 3'b111, 0, 3'b111,  8, 12, 16, 0, 40, 40, 48);
      vecs[7]  = mk(0, 1,  20, 3'b111, 3, 3'b000,  0,  0,  0, 8, 16, 24, 24);
      vecs[8]  = mk(0, 0,   0, 3'b111, 0, 3'b111, 20, 24, 28, 5, 32, 32, 40);
      vecs[9]  = mk(0, 0,   0, 3'b000, 3, 3'b000,  0,  0,  0, 8, 32, 32, 40);
      vecs[10] = mk(0, 0,   0, 3'b000, 3, 3'b000,  0,  0,  0, 8, 32, 32, 40);
      vecs[11] = mk(0, 0,   0, 3'b011, 0, 3'b011, 32, 36,  0, 6, 40, 40, 48);
      vecs[12] = mk(0, 0,   0, 3'b110, 1, 3'b001, 36,  0,  0, 7, 40, 40, 48);
      vecs[13] = mk(1, 1, 100, 3'b111, 3, 3'b000,  0,  0,  0, 8,  0,  0,  8);

      for (int n = 0; n < 14; n++) begin
         apply(vecs[n].rst, vecs[n].flush, vecs[n].target, vecs[n].valid, vecs[n].acc);
         check($sformatf("vec%0d.valid", n), 32'(out_valid), 32'(vecs[n].e_valid));
         check($sformatf("vec%0d.free", n), 32'(free_slots), 32'(vecs[n].e_free));
         for (int i = 0; i < W; i++) begin
            epc = vecs[n].e_pc[i];
            check($sformatf("vec%0d.pc%0d", n, i), out_pc[i], epc);
            check($sformatf("vec%0d.npc%0d", n, i), out_npc[i],
                  vecs[n].e_valid[i] ? epc + 32'd4 : 32'd0);
            check($sformatf("vec%0d.inst%0d", n, i), out_inst[i],
                  vecs[n].e_valid[i] ? inst_of(epc) : 32'd0);
            check($sformatf("vec%0d.addr%0d", n, i), proc2Imem_addr[i], vecs[n].e_addr[i]);
         end
      end

      // Valid hole: only slot 0 is enqueued, low word selected for PC 0.
      apply(1, 0, 0, 3'b000, 0);
      ovr         = 1'b1;
      ovr_data[0] = {32'h0000_000c, 32'h0000_0001};
      ovr_data[1] = 64'h1111_2222_3333_4444;
      ovr_data[2] = 64'h5555_6666_7777_8888;
      apply(0, 0, 0, 3'b101, 0);
      ovr = 1'b0;
      check("hole.valid", 32'(out_valid), 32'b001);
      check("hole.inst0", out_inst[0], 32'h0000_0001);
      check("hole.pc0", out_pc[0], 32'd0);
      check("hole.free", 32'(free_slots), 32'd7);
      check("hole.addr1", proc2Imem_addr[1], 32'd8);

      // Wrap-around streaming: steady state of 3 in, 3 out per cycle.
      apply(1, 0, 0, 3'b000, 0);
      for (int n = 1; n <= 12; n++) begin
         apply(0, 0, 0, 3'b111, 3);
         check($sformatf("stream%0d.valid", n), 32'(out_valid), 32'b111);
         check($sformatf("stream%0d.pc0", n), out_pc[0], 32'(12 * (n - 1)));
         check($sformatf("stream%0d.pc2", n), out_pc[2], 32'(12 * (n - 1) + 8));
         check($sformatf("stream%0d.free", n), 32'(free_slots), 32'd5);
      end

      // Randomized traffic against the reference model.
      model_step(1, 0, 0, 3'b000, 0);
      apply(1, 0, 0, 3'b000, 0);
      check_model("rnd_init");
      for (int n = 0; n < 600; n++) begin
         r = ($urandom_range(0, 99) == 0);
         f = ($urandom_range(0, 99) < 5);
         t = {$urandom_range(0, 255), 2'b00};
         v = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
         a = 2'($urandom_range(0, 3));
         model_step(r, f, t, v, a);
         apply(r, f, t, v, a);
         check_model($sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
